// File: rtl/register_file_custom.sv
// Architectural register file: DEPTH x WIDTH entries, one write port, two
// combinational read ports, optional hardwired-zero entry 0, optional
// write-to-read bypass and a synchronous bulk clear.
module register_file_custom #(
   parameter int unsigned       WIDTH     = 32,
   parameter int unsigned       DEPTH     = 32,
   parameter bit                ZERO_REG  = 1'b1,
   parameter bit                BYPASS    = 1'b1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   localparam int unsigned      ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [WIDTH-1:0]  rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [WIDTH-1:0]  rdata2
);

   logic [WIDTH-1:0] mem [DEPTH];

   logic wr_ok;      // waddr names a real, writable entry
   logic wr_fire;    // a write will land at the next edge
   logic byp_live;   // same-cycle forwarding of wdata is allowed
   logic rd1_ok;
   logic rd2_ok;

   // Address qualification for the write and both read ports
   always_comb begin
      wr_ok    = (32'(waddr) < DEPTH) && !(ZERO_REG && (waddr == '0));
      wr_fire  = we && !clr && wr_ok;
      byp_live = BYPASS && wr_fire && !reset;
      rd1_ok   = (32'(raddr1) < DEPTH) && !(ZERO_REG && (raddr1 == '0));
      rd2_ok   = (32'(raddr2) < DEPTH) && !(ZERO_REG && (raddr2 == '0));
   end

   // Storage: async reset and sync clear both load RESET_VAL; clear beats write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      end else if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      end else if (wr_fire) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port 1: zero for hardwired/out-of-range entries, else bypass or stored
   always_comb begin
      rdata1 = '0;
      if (rd1_ok) begin
         if (byp_live && (raddr1 == waddr)) rdata1 = wdata;
         else                               rdata1 = mem[raddr1];
      end
   end

   // Read port 2: same selection as port 1
   always_comb begin
      rdata2 = '0;
      if (rd2_ok) begin
         if (byp_live && (raddr2 == waddr)) rdata2 = wdata;
         else                               rdata2 = mem[raddr2];
      end
   end

endmodule

// File: tb/tb_register_file_custom.sv
// Bench for register_file_custom: three configurations share one stimulus
// stream and are compared against an array-based model of the register file.
module tb_register_file_custom;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       reset, clr, we;
   logic [2:0] waddr, raddr1, raddr2;
   logic [7:0] wdata;
   logic [7:0] rd1 [NI];
   logic [7:0] rd2 [NI];

   int errors = 0;
   int checks = 0;

   // inst 0: zero reg + bypass, reset value 00
   register_file_custom #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_VAL(8'h00)) u_a (
      .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1[0]), .raddr2(raddr2), .rdata2(rd2[0]));
   // inst 1: normal entry 0, no bypass, reset value 42
   register_file_custom #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0), .RESET_VAL(8'h42)) u_b (
      .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1[1]), .raddr2(raddr2), .rdata2(rd2[1]));
   // inst 2: non-power-of-two depth
   register_file_custom #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_VAL(8'h00)) u_c (
      .clk(clk), .reset(reset), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1[2]), .raddr2(raddr2), .rdata2(rd2[2]));

   always #5 clk = ~clk;

   // configuration of each instance
   function automatic int p_depth(int k);
      return (k == 2) ? 6 : 8;
   endfunction
   function automatic bit p_zero(int k);
      return (k != 1);
   endfunction
   function automatic bit p_byp(int k);
      return (k != 1);
   endfunction
   function automatic logic [7:0] p_rv(int k);
      return (k == 1) ? 8'h42 : 8'h00;
   endfunction

   // reference contents, one array per instance
   logic [7:0] mm [NI][8];

   function automatic bit readable(int k, logic [2:0] a);
      return (int'(a) < p_depth(k)) && !(p_zero(k) && a == 3'd0);
   endfunction

   function automatic logic [7:0] exp_rd(int k, logic [2:0] a);
      if (!readable(k, a)) return 8'h00;
      if (p_byp(k) && we && !clr && !reset && a == waddr) return wdata;
      return mm[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++)
         for (int a = 0; a < 8; a++) mm[k][a] = p_rv(k);
   endtask

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_model(string name);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s_i%0d_p1_a%0d", name, k, raddr1), rd1[k], exp_rd(k, raddr1));
         check($sformatf("%s_i%0d_p2_a%0d", name, k, raddr2), rd2[k], exp_rd(k, raddr2));
      end
   endtask

   // one clock edge; the model takes the write/clear at the edge
   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         for (int k = 0; k < NI; k++) begin
            if (clr) begin
               for (int a = 0; a < 8; a++) mm[k][a] = p_rv(k);
            end else if (we && readable(k, waddr)) begin
               mm[k][waddr] = wdata;
            end
         end
      end
      #1;
   endtask

   typedef struct {
      logic       we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic       clr;
      logic [2:0] r1;
      logic [2:0] r2;
      logic [7:0] e1;
      logic [7:0] e2;
   } vec_t;

   vec_t tbl [10];

   initial begin
      // expectations for inst 0 before each edge, starting from a freshly reset file
      tbl[0] = '{1'b1, 3'd5, 8'hA5, 1'b0, 3'd5, 3'd6, 8'hA5, 8'h00};
      tbl[1] = '{1'b1, 3'd6, 8'h3C, 1'b0, 3'd5, 3'd6, 8'hA5, 8'h3C};
      tbl[2] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd6, 8'hA5, 8'h3C};
      tbl[3] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd6, 8'h00, 8'h3C};
      tbl[4] = '{1'b1, 3'd2, 8'h77, 1'b0, 3'd2, 3'd0, 8'h77, 8'h00};
      tbl[5] = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd2, 8'h00, 8'h77};
      tbl[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 8'h00, 8'h77};
      tbl[7] = '{1'b1, 3'd3, 8'h11, 1'b1, 3'd3, 3'd5, 8'h00, 8'hA5};
      tbl[8] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd6, 8'h00, 8'h00};
      tbl[9] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd2, 8'h00, 8'h00};

      reset = 1'b1; clr = 1'b0; we = 1'b0;
      waddr = 3'd0; wdata = 8'h00; raddr1 = 3'd3; raddr2 = 3'd0;
      model_reset();
      #1;
      check("reset_a_r3", rd1[0], 8'h00);
      check("reset_b_r3", rd1[1], 8'h42);
      check("reset_b_r0", rd2[1], 8'h42);
      check_model("reset");
      tick();
      reset = 1'b0;
      #1;

      // table-driven vectors
      for (int i = 0; i < 10; i++) begin
         we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd; clr = tbl[i].clr;
         raddr1 = tbl[i].r1; raddr2 = tbl[i].r2;
         #1;
         check($sformatf("tbl%0d_p1", i), rd1[0], tbl[i].e1);
         check($sformatf("tbl%0d_p2", i), rd2[0], tbl[i].e2);
         check_model($sformatf("tbl%0d", i));
         tick();
      end
      we = 1'b0; clr = 1'b0;

      // reset asserted mid-run clears without a clock edge and blocks writes
      we = 1'b1; waddr = 3'd3; wdata = 8'h5A; raddr1 = 3'd3; raddr2 = 3'd4;
      tick();
      we = 1'b0; #1;
      check("pre_reset_r3", rd1[0], 8'h5A);
      reset = 1'b1; model_reset(); #1;
      check("async_reset_a_r3", rd1[0], 8'h00);
      check("async_reset_b_r3", rd1[1], 8'h42);
      we = 1'b1; wdata = 8'hEE; clr = 1'b1; #1;
      check("reset_no_bypass", rd1[0], 8'h00);
      check_model("in_reset");
      tick();
      check("reset_blocks_write", rd1[0], 8'h00);
      reset = 1'b0; clr = 1'b0; wdata = 8'h11;
      tick();
      we = 1'b0; #1;
      check("post_reset_r3", rd1[0], 8'h11);
      check_model("post_reset");

      // bypass vs. no bypass on a same-cycle write
      we = 1'b1; waddr = 3'd2; wdata = 8'h77; raddr1 = 3'd2; #1;
      check("bypass_on", rd1[0], 8'h77);
      check("bypass_off_old", rd1[1], 8'h42);
      tick();
      we = 1'b0; #1;
      check("bypass_off_after", rd1[1], 8'h77);

      // entry 0 hardwired vs. normal
      we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr1 = 3'd0; #1;
      check("zero_before", rd1[0], 8'h00);
      check("nonzero_before", rd1[1], 8'h42);
      tick();
      we = 1'b0; #1;
      check("zero_after", rd1[0], 8'h00);
      check("nonzero_after", rd1[1], 8'hFF);

      // fill, then clear collides with a write: clear wins everywhere
      for (int a = 1; a < 8; a++) begin
         we = 1'b1; waddr = 3'(a); wdata = 8'(a * 16);
         tick();
      end
      we = 1'b0; raddr1 = 3'd7; raddr2 = 3'd5; #1;
      check("fill_r7", rd1[0], 8'h70);
      check_model("filled");
      we = 1'b1; clr = 1'b1; waddr = 3'd1; wdata = 8'hEE; raddr1 = 3'd1; #1;
      check_model("clr_we");
      tick();
      we = 1'b0; clr = 1'b0;
      for (int a = 0; a < 8; a++) begin
         raddr1 = 3'(a); #1;
         check($sformatf("clr_a_r%0d", a), rd1[0], 8'h00);
         check($sformatf("clr_b_r%0d", a), rd1[1], 8'h42);
         check_model("cleared");
      end

      // out-of-range address on the depth-6 instance
      for (int a = 1; a < 6; a++) begin
         we = 1'b1; waddr = 3'(a); wdata = 8'(a + 8'h20);
         tick();
      end
      we = 1'b1; waddr = 3'd7; wdata = 8'h99; raddr1 = 3'd7; raddr2 = 3'd5; #1;
      check("oor_bypass", rd1[2], 8'h00);
      tick();
      we = 1'b0; #1;
      check("oor_read", rd1[2], 8'h00);
      check("oor_r5_kept", rd2[2], 8'h25);
      for (int a = 0; a < 8; a++) begin
         raddr1 = 3'(a); #1;
         check_model("oor_scan");
      end

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         reset  = ($urandom_range(0, 59) == 0);
         clr    = ($urandom_range(0, 19) == 0);
         we     = ($urandom_range(0, 2) != 0);
         waddr  = 3'($urandom_range(0, 7));
         wdata  = 8'($urandom);
         raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
         raddr2 = 3'($urandom_range(0, 7));
         if (reset) model_reset();
         #1;
         check_model("rand");
         tick();
      end
      reset = 1'b0; clr = 1'b0; we = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
